// File: rtl/mem_pipe_pkg.sv
// Shared types and helpers for the mem_pipe single-port zero-initialised memory.
package mem_pipe_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  localparam int LATENCY_MAX = 4;
  localparam int PAR_W_MAX   = 64;

  // Even-parity bit over a zero-extended word (words up to PAR_W_MAX bits).
  function automatic logic even_parity(input logic [PAR_W_MAX-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/mem_pipe_delay.sv
// LATENCY-stage valid/data shift register; data stages only load on valid so the
// last stage holds its value between strobes. flush_i drops every valid bit.
module mem_pipe_delay #(
  parameter int W       = 8,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o
);

  logic [LATENCY-1:0] valid_q;
  logic [W-1:0]       data_q [LATENCY];

  // Shift valid and data one stage per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= flush_i ? 1'b0 : in_valid_i;
      if (in_valid_i && !flush_i) begin
        data_q[0] <= in_data_i;
      end
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= flush_i ? 1'b0 : valid_q[i-1];
        if (valid_q[i-1] && !flush_i) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid_o = valid_q[LATENCY-1];
  assign out_data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/mem_pipe.sv
// Zero-initialised memory with pipelined reads. Define MEM_PIPE_PARITY_EN to add
// per-word even parity and the par_err output.
module mem_pipe
  import mem_pipe_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  val,
  input  logic              get,
  input  logic              set,
  output logic              ready,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid
`ifdef MEM_PIPE_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEM_PIPE_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [WIDTH-1:0]  mem_wdata_s;
  logic              accept_s;
  logic              rd_s;
  logic              flush_s;
  logic [DW-1:0]     rd_word_s;
  logic [DW-1:0]     pipe_word_s;

  // Next state, init counter and the single write port (INIT zeroing or accepted set).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = addr;
    mem_wdata_s = val;
    case (state_q)
      ST_INIT: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = cnt_q;
        mem_wdata_s = {WIDTH{1'b0}};
        if (clear) begin
          cnt_d = {ADDR_W{1'b0}};
        end else if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_IDLE;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_INIT;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          mem_we_s = set;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State and init counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage array; contents are only defined once INIT has swept it.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign accept_s = ready && !clear && (get || set);
  // A simultaneous set wins: write only, no read issued.
  assign rd_s     = accept_s && !set;
  assign flush_s  = clear || (state_q == ST_INIT);

`ifdef MEM_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q;

  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      par_q[mem_waddr_s] <= even_parity(PAR_W_MAX'(mem_wdata_s));
    end
  end

  assign rd_word_s = {par_q[addr] != even_parity(PAR_W_MAX'(mem_q[addr])), mem_q[addr]};
  assign par_err   = pipe_word_s[WIDTH];
`else
  assign rd_word_s = mem_q[addr];
`endif

  mem_pipe_delay #(
    .W       (DW),
    .LATENCY (LATENCY)
  ) u_delay (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_s),
    .in_valid_i  (rd_s),
    .in_data_i   (rd_word_s),
    .out_valid_o (out_valid),
    .out_data_o  (pipe_word_s)
  );

  assign out = pipe_word_s[WIDTH-1:0];

endmodule

// File: tb/tb_mem_pipe.sv
// Directed bench for mem_pipe (WIDTH=8, ADDR_W=8, LATENCY=3).
module tb_mem_pipe;

  localparam int LAT = 3;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [7:0] addr;
  logic [7:0] val;
  logic       get;
  logic       set;
  logic       ready;
  logic [7:0] out;
  logic       out_valid;
`ifdef MEM_PIPE_PARITY_EN
  logic       par_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  mem_pipe #(
    .WIDTH   (8),
    .ADDR_W  (8),
    .LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .addr      (addr),
    .val       (val),
    .get       (get),
    .set       (set),
    .ready     (ready),
    .out       (out),
    .out_valid (out_valid)
`ifdef MEM_PIPE_PARITY_EN
    ,
    .par_err   (par_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a;
    val  = d;
    set  = 1'b1;
    tick();
    set  = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    int lat;
    addr = a;
    get  = 1'b1;
    tick();
    get  = 1'b0;
    lat  = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(LAT - 1));
    check_eq({tag, "_data"}, 32'(out), 32'(exp));
    tick();
    check_eq({tag, "_strobe"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_hold"}, 32'(out), 32'(exp));
  endtask

  initial begin
    int cyc;
    int ov_cnt;
    rst_n = 1'b0;
    clear = 1'b0;
    addr  = 8'h00;
    val   = 8'h00;
    get   = 1'b0;
    set   = 1'b0;
    tick();
    tick();
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_out", 32'(out), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);

    // Reset release: INIT sweeps 256 words before ready rises.
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!ready && cyc < 400);
    check_eq("init_len", 32'(cyc), 32'd256);
    rd_check("rd_zero_37", 8'h37, 8'h00);

    // Write then read next cycle.
    wr(8'h10, 8'hA5);
    rd_check("rd_after_wr", 8'h10, 8'hA5);

    // Back-to-back reads return in issue order.
    wr(8'h01, 8'h11);
    wr(8'h02, 8'h22);
    wr(8'h03, 8'h33);
    get = 1'b1;
    addr = 8'h01; tick();
    addr = 8'h02; tick();
    check_eq("b2b_early", 32'(out_valid), 32'd0);
    addr = 8'h03; tick();
    get = 1'b0;
    check_eq("b2b_v0", 32'(out_valid), 32'd1);
    check_eq("b2b_d0", 32'(out), 32'h11);
    tick();
    check_eq("b2b_v1", 32'(out_valid), 32'd1);
    check_eq("b2b_d1", 32'(out), 32'h22);
    tick();
    check_eq("b2b_v2", 32'(out_valid), 32'd1);
    check_eq("b2b_d2", 32'(out), 32'h33);
    tick();
    check_eq("b2b_end", 32'(out_valid), 32'd0);

    // set and get together: write only.
    addr = 8'h20; val = 8'h5A; set = 1'b1; get = 1'b1;
    tick();
    set = 1'b0; get = 1'b0;
    ov_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) ov_cnt++;
      tick();
    end
    check_eq("setget_no_valid", 32'(ov_cnt), 32'd0);
    rd_check("setget_rd", 8'h20, 8'h5A);

    // Read then clear: read flushed, INIT repeats, stray writes during INIT dropped.
    addr = 8'h10; get = 1'b1;
    tick();
    get = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr_ready_low", 32'(ready), 32'd0);
    addr = 8'h00; val = 8'hEE; set = 1'b1;
    cyc = 0;
    ov_cnt = 0;
    while (!ready && cyc < 400) begin
      cyc++;
      tick();
      if (out_valid) ov_cnt++;
    end
    set = 1'b0;
    check_eq("clr_init_len", 32'(cyc), 32'd256);
    check_eq("clr_flush", 32'(ov_cnt), 32'd0);
    rd_check("clr_rd_10", 8'h10, 8'h00);
    rd_check("clr_rd_00", 8'h00, 8'h00);

    // Address 0xFF is the last word of the array.
    wr(8'hFF, 8'hC3);
    rd_check("rd_top", 8'hFF, 8'hC3);

`ifdef MEM_PIPE_PARITY_EN
    wr(8'h40, 8'h0F);
    wr(8'h41, 8'h0F);
    @(negedge clk);
    dut.mem_q[64] = dut.mem_q[64] ^ 8'h01;
    tick();
    addr = 8'h40; get = 1'b1; tick(); get = 1'b0;
    tick(); tick();
    check_eq("par_bad_valid", 32'(out_valid), 32'd1);
    check_eq("par_bad_err", 32'(par_err), 32'd1);
    addr = 8'h41; get = 1'b1; tick(); get = 1'b0;
    tick(); tick();
    check_eq("par_ok_valid", 32'(out_valid), 32'd1);
    check_eq("par_ok_err", 32'(par_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_pipe.md
MEM_PIPE -- requirements
Module: mem_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter LATENCY, default 1, read latency in cycles; legal range 1..4.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port clear, input, 1, request to re-zero the whole array.
REQ-007 SHALL have port addr, input, ADDR_W, word address.
REQ-008 SHALL have port val, input, WIDTH, write data.
REQ-009 SHALL have port get, input, 1, read request.
REQ-010 SHALL have port set, input, 1, write request.
REQ-011 SHALL have port ready, output, 1, high when requests are accepted.
REQ-012 SHALL have port out, output, WIDTH, read data.
REQ-013 SHALL have port out_valid, output, 1, one-cycle strobe qualifying out.
REQ-014 SHALL have port par_err, output, 1, parity error on the word in out; present only with MEM_PIPE_PARITY_EN.

Function
REQ-015 SHALL implement FSM states INIT and IDLE; ready = (state == IDLE).
REQ-016 INIT SHALL write zero to one word per cycle, address counter 0 to DEPTH-1, then go to IDLE; INIT lasts exactly DEPTH cycles.
REQ-017 clear sampled high in IDLE SHALL move to INIT on the next edge, counter restarted at 0; clear in INIT SHALL restart the counter at 0.
REQ-018 A request SHALL be accepted on an edge where ready=1, clear=0 and (get|set)=1; requests with ready=0 or clear=1 are dropped, not queued.
REQ-019 set and get both high SHALL perform the write only; no read issued, no out_valid.
REQ-020 Accepted write SHALL update data[addr] with val at the accepting edge.
REQ-021 Accepted read SHALL sample data[addr] at the accepting edge and present it on out with out_valid=1 exactly LATENCY cycles after acceptance.
REQ-022 Back-to-back reads SHALL be accepted every cycle; throughput one read per cycle, results in issue order.
REQ-023 Read accepted the cycle after a write to the same address SHALL return the new data.
REQ-024 out SHALL hold its last value while out_valid=0.
REQ-025 Entry to INIT (clear or reset) SHALL flush in-flight reads: no out_valid for reads issued before entry.
REQ-026 Address arithmetic SHALL be modulo DEPTH; no out-of-range condition exists.

Reset
REQ-027 rst_n low SHALL asynchronously force state=INIT, counter=0, ready=0, out=0, out_valid=0, par_err=0, read pipeline valid bits=0.
REQ-028 After rst_n deasserts, the array SHALL read as all-zero once ready rises; contents before that are undefined.

Configuration
REQ-029 Macro MEM_PIPE_PARITY_EN SHALL, when defined, store one even-parity bit per word (written on set and on INIT zeroing), recompute on read, and drive par_err=1 with out_valid when stored and computed parity differ.
REQ-030 Without MEM_PIPE_PARITY_EN, no parity storage and no par_err port SHALL exist; all other behaviour identical.

Structure
REQ-031 Package mem_pipe_pkg SHALL hold the FSM state enum, LATENCY_MAX = 4 and the parity helper function.
REQ-032 Sub-module mem_pipe_delay SHALL implement the LATENCY-stage valid/data shift register with flush input; mem_pipe instantiates it once.

Verification
REQ-033 Reset, then count cycles -> ready rises exactly 256 cycles after rst_n release (ADDR_W=8); read addr 0x37 -> out=0x00.
REQ-034 Write 0xA5 to 0x10, next cycle read 0x10 with LATENCY=3 -> out=0xA5, out_valid high exactly 3 cycles after read acceptance, for one cycle.
REQ-035 Reads of 0x01,0x02,0x03 on consecutive cycles after writing 0x11,0x22,0x33 -> out_valid three consecutive cycles, data 0x11,0x22,0x33 in order.
REQ-036 set=get=1, addr 0x20, val 0x5A -> no out_valid; later read 0x20 -> 0x5A.
REQ-037 Read issued, clear asserted next cycle -> no out_valid for that read, ready low 256 cycles, then read of previously written address -> 0x00.
REQ-038 With MEM_PIPE_PARITY_EN, force-flip one stored data bit at 0x40 then read -> par_err=1 with out_valid; unmodified address -> par_err=0.
